de_regfile_scoreboard: RTL and testbench
========================================

// Module: de_regfile_scoreboard
// PURPOSE
//  Decode-side receiver of the write-back bus (from_WB_to_DE = {wr_reg, wregno, regval}).
//  Holds the architectural register file and a per-register pending-write scoreboard.
//  Supplies rs1/rs2 operands to DE and raises a stall on RAW/WAW hazards until WB retires the writer.
// PARAMETERS
//  DBITS      32  data width
//  REGNOBITS  5   register index width
//  REGWORDS   32  number of registers; x0 hard-wired to zero
//  PEND_BITS  2   pending-counter width per register; max in-flight writers = 2**PEND_BITS-1
// PORTS
//  clk           in   1          pipeline clock
//  reset         in   1          synchronous, active-high
//  wb_wr_reg     in   1          WB write enable (from_WB_to_DE msb)
//  wb_wregno     in   REGNOBITS  WB destination register
//  wb_regval     in   DBITS      WB write data
//  de_valid      in   1          DE holds a valid instruction this cycle
//  de_rs1        in   REGNOBITS  source 1 index
//  de_rs2        in   REGNOBITS  source 2 index
//  de_rs1_used   in   1          instruction reads rs1
//  de_rs2_used   in   1          instruction reads rs2
//  de_wr_reg     in   1          instruction writes rd
//  de_rd         in   REGNOBITS  destination index
//  rs1_val       out  DBITS      operand 1 (combinational)
//  rs2_val       out  DBITS      operand 2 (combinational)
//  de_stall      out  1          hold DE/FE this cycle; instruction not issued
//  wb_unexpected out  1          sticky: WB wrote a register with pending count 0
// BEHAVIOUR
//  - Reset (sync, overrides everything): all registers 0, all pending counters 0, wb_unexpected 0.
//    While reset is high de_stall=0, rs1_val=rs2_val=0.
//  - Reads: index 0 always returns 0. Otherwise array value (plus bypass, see CONFIGURATION).
//  - Write: on posedge, if wb_wr_reg && wb_wregno!=0, reg[wb_wregno] <= wb_regval. Writes to x0 dropped.
//  - busy(r) = (r!=0) && cnt[r]!=0, except as relaxed by bypass.
//  - de_stall = de_valid && ((de_rs1_used && busy(de_rs1)) || (de_rs2_used && busy(de_rs2))
//               || (de_wr_reg && de_rd!=0 && cnt[de_rd]==MAX)).
//  - issue = de_valid && !de_stall && de_wr_reg && de_rd!=0 -> cnt[de_rd] += 1.
//  - retire = wb_wr_reg && wb_wregno!=0 -> cnt[wb_wregno] -= 1.
//  - Same register issued and retired in one cycle: counter unchanged.
//  - Retire with cnt==0: register still written, counter stays 0 (no underflow), wb_unexpected <= 1.
//  - Counter never exceeds MAX (guaranteed by the stall term); no wrap-around.
//  - WAW: multiple in-flight writers to one rd allowed up to MAX; a reader waits until cnt returns to 0.
//  - Latency: issue visible in cnt next cycle; WB write visible in array next cycle.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: when wb_wr_reg && wb_wregno==rsX && rsX!=0, rsX_val = wb_regval,
//    and busy(rsX) ignores a count of exactly 1 (the retiring writer) -> zero-bubble WB->DE.
//  Undefined: no bypass; a reader stalls through the WB cycle and reads the array the following
//    cycle (one extra stall cycle per dependency).
// TESTING
//  1 Reset, then read x1..x31 -> all 0, de_stall=0, wb_unexpected=0.
//  2 Issue rd=5; next cycle read rs1=5 -> de_stall=1 until WB writes x5=0xDEADBEEF; bypass on:
//    stall drops in WB cycle with rs1_val=0xDEADBEEF; bypass off: stall drops one cycle later, same value.
//  3 WB write x0=0x1234 -> rs1=0 reads 0; cnt[0] stays 0; wb_unexpected stays 0.
//  4 Issue rd=7 three times (PEND_BITS=2) -> fourth issue to rd=7 stalls; retire one -> fourth issues.
//  5 Same cycle: issue rd=9 and WB retire x9 with cnt[9]=1 -> cnt[9] stays 1, reader of x9 stalls.
//  6 WB write x3 with cnt[3]=0 -> x3 updated, wb_unexpected=1 and stays 1 until reset;
//    assert reset mid-flight with cnt!=0 -> all counters 0 next cycle, de_stall=0.

Source files
------------

// File: rtl/de_regfile_scoreboard.sv
// rtl/de_regfile_scoreboard.sv - DE register file with per-register pending-write scoreboard (option: REGFILE_BYPASS_EN)
module de_regfile_scoreboard #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 5,
  parameter int REGWORDS  = 32,
  parameter int PEND_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_wr_reg,
  input  logic [REGNOBITS-1:0] wb_wregno,
  input  logic [DBITS-1:0]     wb_regval,
  input  logic                 de_valid,
  input  logic [REGNOBITS-1:0] de_rs1,
  input  logic [REGNOBITS-1:0] de_rs2,
  input  logic                 de_rs1_used,
  input  logic                 de_rs2_used,
  input  logic                 de_wr_reg,
  input  logic [REGNOBITS-1:0] de_rd,
  output logic [DBITS-1:0]     rs1_val,
  output logic [DBITS-1:0]     rs2_val,
  output logic                 de_stall,
  output logic                 wb_unexpected
);

`ifdef REGFILE_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  localparam logic [PEND_BITS-1:0] CNT_MAX = '1;
  localparam logic [PEND_BITS-1:0] CNT_ONE = PEND_BITS'(1);

  logic [DBITS-1:0]     regs [REGWORDS];
  logic [PEND_BITS-1:0] cnt  [REGWORDS];

  logic rs1_hit, rs2_hit;
  logic rs1_busy, rs2_busy, rd_full;
  logic issue, retire, same_reg;

  // Operand read with optional WB forwarding, hazard detection and issue/retire qualification
  always_comb begin
    rs1_hit  = BYPASS && wb_wr_reg && (wb_wregno == de_rs1) && (de_rs1 != '0);
    rs2_hit  = BYPASS && wb_wr_reg && (wb_wregno == de_rs2) && (de_rs2 != '0);

    rs1_val = '0;
    if (!reset && de_rs1 != '0) rs1_val = rs1_hit ? wb_regval : regs[de_rs1];
    rs2_val = '0;
    if (!reset && de_rs2 != '0) rs2_val = rs2_hit ? wb_regval : regs[de_rs2];

    // A count of exactly one that is retiring right now is covered by the forwarded value
    rs1_busy = (de_rs1 != '0) && (cnt[de_rs1] != '0) && !(rs1_hit && cnt[de_rs1] == CNT_ONE);
    rs2_busy = (de_rs2 != '0) && (cnt[de_rs2] != '0) && !(rs2_hit && cnt[de_rs2] == CNT_ONE);
    rd_full  = de_wr_reg && (de_rd != '0) && (cnt[de_rd] == CNT_MAX);

    de_stall = !reset && de_valid &&
               ((de_rs1_used && rs1_busy) || (de_rs2_used && rs2_busy) || rd_full);
    issue    = !reset && de_valid && !de_stall && de_wr_reg && (de_rd != '0);
    retire   = wb_wr_reg && (wb_wregno != '0);
    same_reg = issue && retire && (wb_wregno == de_rd);
  end

  // Architectural register array; x0 writes are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REGWORDS; i++) regs[i] <= '0;
    end else if (retire) begin
      regs[wb_wregno] <= wb_regval;
    end
  end

  // Pending-writer counters and sticky unexpected-retire flag
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REGWORDS; i++) cnt[i] <= '0;
      wb_unexpected <= 1'b0;
    end else begin
      if (issue && !same_reg) cnt[de_rd] <= cnt[de_rd] + CNT_ONE;
      if (retire && !same_reg && cnt[wb_wregno] != '0) cnt[wb_wregno] <= cnt[wb_wregno] - CNT_ONE;
      if (retire && cnt[wb_wregno] == '0) wb_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_de_regfile_scoreboard.sv
// tb/tb_de_regfile_scoreboard.sv - self-checking bench for de_regfile_scoreboard
module tb_de_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_wr_reg = 1'b0;
  logic [4:0]  wb_wregno = '0;
  logic [31:0] wb_regval = '0;
  logic        de_valid = 1'b0;
  logic [4:0]  de_rs1 = '0;
  logic [4:0]  de_rs2 = '0;
  logic        de_rs1_used = 1'b0;
  logic        de_rs2_used = 1'b0;
  logic        de_wr_reg = 1'b0;
  logic [4:0]  de_rd = '0;
  logic [31:0] rs1_val, rs2_val;
  logic        de_stall, wb_unexpected;

  int checks = 0;
  int errors = 0;
  logic live = 1'b0;

  // reference state: register contents, in-flight writer counts, sticky flag
  logic [31:0] m_reg [32];
  int          m_cnt [32];
  logic        m_unexp;

  de_regfile_scoreboard dut (
    .clk(clk), .reset(reset),
    .wb_wr_reg(wb_wr_reg), .wb_wregno(wb_wregno), .wb_regval(wb_regval),
    .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
    .de_wr_reg(de_wr_reg), .de_rd(de_rd),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .de_stall(de_stall), .wb_unexpected(wb_unexpected)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic wb_hits(input logic [4:0] r);
`ifdef REGFILE_BYPASS_EN
    return wb_wr_reg && wb_wregno == r && r != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (reset || r == 0) return 32'h0;
    if (wb_hits(r)) return wb_regval;
    return m_reg[r];
  endfunction

  function automatic logic m_busy(input logic [4:0] r);
    if (r == 0) return 1'b0;
    if (wb_hits(r) && m_cnt[r] == 1) return 1'b0;
    return m_cnt[r] != 0;
  endfunction

  function automatic logic m_stall();
    if (reset || !de_valid) return 1'b0;
    if (de_rs1_used && m_busy(de_rs1)) return 1'b1;
    if (de_rs2_used && m_busy(de_rs2)) return 1'b1;
    if (de_wr_reg && de_rd != 0 && m_cnt[de_rd] == 3) return 1'b1;
    return 1'b0;
  endfunction

  // reference state advance at each clock
  always @(posedge clk) begin
    logic st, iss, ret;
    if (reset) begin
      for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_cnt[i] = 0; end
      m_unexp = 1'b0;
    end else begin
      st  = m_stall();
      iss = de_valid && !st && de_wr_reg && de_rd != 0;
      ret = wb_wr_reg && wb_wregno != 0;
      if (ret) begin
        m_reg[wb_wregno] = wb_regval;
        if (m_cnt[wb_wregno] == 0) m_unexp = 1'b1;
      end
      if (!(iss && ret && de_rd == wb_wregno)) begin
        if (ret && m_cnt[wb_wregno] > 0) m_cnt[wb_wregno] = m_cnt[wb_wregno] - 1;
        if (iss) m_cnt[de_rd] = m_cnt[de_rd] + 1;
      end
    end
  end

  // every-cycle comparison against the reference
  always @(negedge clk) begin
    if (live) begin
      chk("cmp_rs1_val", rs1_val, m_read(de_rs1));
      chk("cmp_rs2_val", rs2_val, m_read(de_rs2));
      chk("cmp_de_stall", 32'(de_stall), 32'(m_stall()));
      chk("cmp_wb_unexpected", 32'(wb_unexpected), 32'(m_unexp));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_wr_reg = 0; wb_wregno = 0; wb_regval = 0;
    de_valid = 0; de_rs1 = 0; de_rs2 = 0; de_rs1_used = 0; de_rs2_used = 0;
    de_wr_reg = 0; de_rd = 0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic issue_rd(input logic [4:0] rd);
    idle(); de_valid = 1; de_wr_reg = 1; de_rd = rd;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] v);
    wb_wr_reg = 1; wb_wregno = r; wb_regval = v;
  endtask

  initial begin
    // 1: reset, then every register reads zero
    tick(); live = 1'b1; tick(); reset = 0;
    for (int r = 1; r < 32; r++) begin
      idle(); de_valid = 1; de_rs1 = 5'(r); de_rs2 = 5'(32 - r); de_rs1_used = 1; de_rs2_used = 1;
      settle();
      chk("s1_rs1_zero", rs1_val, 32'h0);
      chk("s1_stall", 32'(de_stall), 32'h0);
      tick();
    end
    chk("s1_unexp", 32'(wb_unexpected), 32'h0);

    // 2: RAW on x5
    issue_rd(5); settle(); chk("s2_issue", 32'(de_stall), 32'h0);
    tick(); idle(); de_valid = 1; de_rs1 = 5; de_rs1_used = 1;
    settle(); chk("s2_raw_stall_a", 32'(de_stall), 32'h1);
    tick(); settle(); chk("s2_raw_stall_b", 32'(de_stall), 32'h1);
    tick(); wb(5, 32'hDEADBEEF); settle();
`ifdef REGFILE_BYPASS_EN
    chk("s2_wb_cycle_stall", 32'(de_stall), 32'h0);
    chk("s2_wb_cycle_val", rs1_val, 32'hDEADBEEF);
`else
    chk("s2_wb_cycle_stall", 32'(de_stall), 32'h1);
`endif
    tick(); wb_wr_reg = 0; settle();
    chk("s2_after_stall", 32'(de_stall), 32'h0);
    chk("s2_after_val", rs1_val, 32'hDEADBEEF);

    // 3: writes to x0 are dropped and do not count as unexpected
    tick(); idle(); wb(0, 32'h1234);
    tick(); idle(); de_valid = 1; de_rs1 = 0; de_rs1_used = 1; de_wr_reg = 1; de_rd = 0;
    settle(); chk("s3_x0_val", rs1_val, 32'h0); chk("s3_unexp", 32'(wb_unexpected), 32'h0);

    // 4: three writers to x7 fill the counter
    for (int k = 0; k < 3; k++) begin
      tick(); issue_rd(7); settle(); chk("s4_fill", 32'(de_stall), 32'h0);
    end
    tick(); issue_rd(7); settle(); chk("s4_full_stall", 32'(de_stall), 32'h1);
    tick(); wb(7, 32'h70); settle(); chk("s4_full_during_retire", 32'(de_stall), 32'h1);
    tick(); wb_wr_reg = 0; settle(); chk("s4_fourth_issues", 32'(de_stall), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick(); idle(); wb(7, 32'h71 + 32'(k));
    end
    tick(); idle(); de_valid = 1; de_rs2 = 7; de_rs2_used = 1;
    settle(); chk("s4_drained", 32'(de_stall), 32'h0); chk("s4_val", rs2_val, 32'h73);

    // 5: issue and retire x9 in the same cycle
    tick(); issue_rd(9);
    tick(); issue_rd(9); wb(9, 32'h99); settle(); chk("s5_issue_ok", 32'(de_stall), 32'h0);
    tick(); idle(); de_valid = 1; de_rs1 = 9; de_rs1_used = 1;
    settle(); chk("s5_still_pending", 32'(de_stall), 32'h1);
    tick(); wb(9, 32'h9A); settle();
`ifdef REGFILE_BYPASS_EN
    chk("s5_retire_bypass", rs1_val, 32'h9A);
`else
    chk("s5_retire_stall", 32'(de_stall), 32'h1);
`endif
    tick(); idle(); settle(); chk("s5_unexp_clear", 32'(wb_unexpected), 32'h0);

    // 6: unexpected retire to x3, then reset mid-flight
    tick(); idle(); wb(3, 32'h33);
    tick(); idle(); de_rs2 = 3; settle();
    chk("s6_x3_val", rs2_val, 32'h33); chk("s6_unexp_set", 32'(wb_unexpected), 32'h1);
    tick(); tick(); settle(); chk("s6_unexp_sticky", 32'(wb_unexpected), 32'h1);
    tick(); issue_rd(11);
    tick(); issue_rd(12);
    tick(); idle(); de_valid = 1; de_rs1 = 11; de_rs1_used = 1; de_rs2 = 12; de_rs2_used = 1;
    settle(); chk("s6_pending_stall", 32'(de_stall), 32'h1);
    tick(); reset = 1; settle();
    chk("s6_reset_stall", 32'(de_stall), 32'h0); chk("s6_reset_val", rs2_val, 32'h0);
    tick(); reset = 0; settle();
    chk("s6_post_stall", 32'(de_stall), 32'h0);
    chk("s6_post_unexp", 32'(wb_unexpected), 32'h0);
    tick(); idle(); de_rs1 = 3; settle(); chk("s6_post_x3", rs1_val, 32'h0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
